instruction_queue_controller: RTL and testbench
===============================================

# instruction_queue_controller

- Parametrised successor of the single-slot instruction latch in the operation controller.
- Holds a DEPTH-entry prefetch FIFO between the instruction bus and the issue stage, driven by the external one-hot three-phase sequence.
- Issues one instruction per phase-3 edge into `current_instruction` / `last_instruction`.
- Supports stall and control-flow flush, inserts NOP bubbles on underflow, and counts bubbles.

## Interface
Parameters:
- XLEN, 32, instruction/data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0)
- CNT_W, 16, bubble counter width

Ports (`phase` is one-hot, exactly one bit high per cycle):
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting clears all state immediately
- phase  in  3  one-hot [3:1] phase from the phase generator
- fetch_data  in  XLEN  instruction word from the bus
- fetch_valid  in  1  bus has valid `fetch_data` this cycle (phase 2 only)
- stall  in  1  issue stage cannot accept; sampled at phase 3
- flush  in  1  taken jump/branch; sampled at phase 3
- fetch_request  out  1  request the next instruction word
- current_instruction  out  XLEN  instruction in decode/execute
- last_instruction  out  XLEN  previous issued instruction (second-part ops)
- issue_valid  out  1  `current_instruction` came from the FIFO, not a bubble
- queue_count  out  $clog2(DEPTH+1)  occupied entries
- queue_empty  out  1  `queue_count == 0`
- queue_full  out  1  `queue_count == DEPTH`
- bubble_count  out  CNT_W  saturating count of underflow bubbles

## Operation
- Reset (asynchronous, active-low) sets:
  - `current_instruction` = `last_instruction` = NOP
  - `issue_valid` = 0, count = 0, `bubble_count` = 0
  - read/write pointers = 0, `queue_empty` = 1, `queue_full` = 0
- `fetch_request` = phase[1] & ~`queue_full` (combinational). Requests only when a slot is guaranteed free at phase 2; a pop never happens in phase 1 or 2.
- Push at phase 2: if `fetch_valid` & ~full, write `fetch_data` at wptr, wptr+1 mod DEPTH, count+1. If `fetch_valid` is low, no push; this is a wait state, not an error.
- Issue at phase 3, in priority order:
  1. `flush`:
     - rptr = wptr = count = 0
     - `last_instruction` <= `current_instruction`
     - `current_instruction` <= NOP, `issue_valid` <= 0
     - `bubble_count` unchanged; flush bubbles are not underflow
     - `stall` ignored
  2. `stall`: `current_instruction`, `last_instruction`, `issue_valid` and FIFO hold.
  3. Not empty: `last_instruction` <= `current_instruction`; `current_instruction` <= mem[rptr]; rptr+1 mod DEPTH; count-1; `issue_valid` <= 1.
  4. Empty: `last_instruction` <= `current_instruction`; `current_instruction` <= NOP; `issue_valid` <= 0; `bubble_count` +1, saturating at all-ones.
- `flush` and `stall` are ignored outside phase 3.
- Pointers are $clog2(DEPTH) bits and wrap naturally; `queue_count` is the sole full/empty source.
- Illegal phase vectors (zero or multi-hot): no state change.

## Timing
- Fetch-to-issue latency: a word pushed at phase 2 with the FIFO empty issues at the immediately following phase-3 edge.
- Throughput: one issue per 3-cycle phase round.
- `fetch_request`, `queue_empty`, `queue_full` are combinational from registered count/phase.
- All other outputs are registered.
- Reset asserted mid-round takes effect without a clock edge. After release, the first phase 3 issues NOP and increments `bubble_count` unless a push occurred in the preceding phase 2.

## Structure
- Shared package `rv_pipeline_pkg`: NOP constant, phase index localparams (PH_FETCH=1, PH_LOAD=2, PH_ISSUE=3).
- One sub-module `sync_fifo_mem`: DEPTH×XLEN register array with write port and combinational read by pointer.
- The controller owns the pointers, count and issue registers.

## Test plan
- Reset: hold reset low mid-phase 2 -> all outputs at reset values immediately; `fetch_request` = 1 at next phase 1.
- Fill: DEPTH=4, `stall` = 1, push 0x00100093, 0x00200113, 0x00300193, 0x00400213 -> count 4, full = 1, `fetch_request` = 0 at phase 1, a 5th word at phase 2 is dropped.
- Drain in order: release `stall` -> `current_instruction` sequence 0x00100093, 0x00200113, … with `last_instruction` lagging one issue; after the 4th, the next phase 3 gives NOP, `issue_valid` = 0, `bubble_count` = 1.
- Flush: queue holds 3 words; `flush` = 1 with `stall` = 1 at phase 3 -> count 0, `current_instruction` = NOP, `bubble_count` unchanged; next push issues normally.
- Wrap-around: 10 push/issue rounds with DEPTH=4 -> order preserved across pointer wrap, count never exceeds 4.
- Saturation: CNT_W=4, 20 empty issue rounds -> `bubble_count` = 15.

Source files
------------

// File: rtl/rv_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// rv_pipeline_pkg
// Shared constants and types for the instruction fetch/issue pipeline.
//   NOP_INSTR   : canonical bubble instruction (addi x0,x0,0)
//   PH_*        : bit indices into the one-hot [3:1] phase vector
//   issue_act_e : what the issue stage does at a phase-3 edge
// ---------------------------------------------------------------------------
package rv_pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int PH_FETCH = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_ISSUE = 3;

    // Issue decisions, listed in priority order.
    typedef enum logic [1:0] {
        ISSUE_FLUSH,
        ISSUE_HOLD,
        ISSUE_POP,
        ISSUE_BUBBLE
    } issue_act_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x XLEN register array backing the instruction prefetch FIFO.
// Ports:
//   clock      : rising-edge clock
//   wr_en_i    : write wr_data_i into entry wr_addr_i on this edge
//   wr_addr_i  : write pointer
//   wr_data_i  : word to store
//   rd_addr_i  : read pointer
//   rd_data_o  : combinational read of entry rd_addr_i
// ---------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [XLEN-1:0]          wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [XLEN-1:0]          rd_data_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; entry validity is tracked entirely
    // by the controller's count, so stale contents are never issued and the
    // array maps onto plain registers or RAM without a reset network.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instruction_queue_controller.sv
// ---------------------------------------------------------------------------
// instruction_queue_controller
// Prefetch FIFO between the instruction bus and the issue stage, sequenced by
// an external one-hot three-phase vector: phase 1 requests, phase 2 loads,
// phase 3 issues one instruction (or a NOP bubble on underflow).
// Ports:
//   clock, reset         : rising-edge clock, async active-low reset
//   phase[3:1]           : one-hot phase (1 fetch, 2 load, 3 issue)
//   fetch_data/valid     : bus word and its valid (used at phase 2)
//   stall, flush         : issue-stage hold / control-flow flush (phase 3)
//   fetch_request        : ask the bus for a word (phase 1, not full)
//   current_instruction  : instruction in decode/execute
//   last_instruction     : previously issued instruction
//   issue_valid          : current_instruction came from the FIFO
//   queue_count/empty/full : FIFO occupancy
//   bubble_count         : saturating count of underflow bubbles
// ---------------------------------------------------------------------------
module instruction_queue_controller
    import rv_pipeline_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 4,
    parameter logic [XLEN-1:0] NOP   = XLEN'(NOP_INSTR),
    parameter int              CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3:1]                 phase,
    input  logic [XLEN-1:0]            fetch_data,
    input  logic                       fetch_valid,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       fetch_request,
    output logic [XLEN-1:0]            current_instruction,
    output logic [XLEN-1:0]            last_instruction,
    output logic                       issue_valid,
    output logic [$clog2(DEPTH+1)-1:0] queue_count,
    output logic                       queue_empty,
    output logic                       queue_full,
    output logic [CNT_W-1:0]           bubble_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);

    logic [PTR_W-1:0] rptr_q, wptr_q;
    logic [CW-1:0]    count_q;
    logic [XLEN-1:0]  cur_q, last_q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_q;

    logic             phase_ok;
    logic             push_en;
    logic             issue_en;
    logic [XLEN-1:0]  head_word;
    issue_act_e       issue_act;

    // Zero or multi-hot phase vectors must not move any state.
    assign phase_ok = $onehot(phase);
    assign push_en  = phase_ok & phase[PH_LOAD] & fetch_valid & ~queue_full;
    assign issue_en = phase_ok & phase[PH_ISSUE];

    assign queue_empty   = (count_q == '0);
    assign queue_full    = (count_q == CW'(DEPTH));
    // A pop never happens in phases 1-2, so "not full" at phase 1 guarantees
    // a free slot for the phase-2 load.
    assign fetch_request = phase[PH_FETCH] & ~queue_full;

    // NOTE: every output of a combinational block gets a default before any
    // branch so that no path leaves it unassigned and infers a latch.
    always_comb begin
        issue_act = ISSUE_HOLD;
        if (flush) begin
            issue_act = ISSUE_FLUSH;
        end else if (stall) begin
            issue_act = ISSUE_HOLD;
        end else if (!queue_empty) begin
            issue_act = ISSUE_POP;
        end else begin
            issue_act = ISSUE_BUBBLE;
        end
    end

    sync_fifo_mem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock     (clock),
        .wr_en_i   (push_en),
        .wr_addr_i (wptr_q),
        .wr_data_i (fetch_data),
        .rd_addr_i (rptr_q),
        .rd_data_o (head_word)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            cur_q    <= NOP;
            last_q   <= NOP;
            valid_q  <= 1'b0;
            bubble_q <= '0;
        end else begin
            // Push (phase 2) and issue (phase 3) are mutually exclusive.
            if (push_en) begin
                wptr_q  <= wptr_q + PTR_W'(1);
                count_q <= count_q + CW'(1);
            end
            if (issue_en) begin
                unique case (issue_act)
                    ISSUE_FLUSH: begin
                        rptr_q  <= '0;
                        wptr_q  <= '0;
                        count_q <= '0;
                        last_q  <= cur_q;
                        cur_q   <= NOP;
                        valid_q <= 1'b0;
                    end
                    ISSUE_HOLD: begin
                    end
                    ISSUE_POP: begin
                        last_q  <= cur_q;
                        cur_q   <= head_word;
                        rptr_q  <= rptr_q + PTR_W'(1);
                        count_q <= count_q - CW'(1);
                        valid_q <= 1'b1;
                    end
                    ISSUE_BUBBLE: begin
                        last_q  <= cur_q;
                        cur_q   <= NOP;
                        valid_q <= 1'b0;
                        if (bubble_q != '1) begin
                            bubble_q <= bubble_q + CNT_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign current_instruction = cur_q;
    assign last_instruction    = last_q;
    assign issue_valid         = valid_q;
    assign queue_count         = count_q;
    assign bubble_count        = bubble_q;

endmodule

// File: tb/tb_instruction_queue_controller.sv
// ---------------------------------------------------------------------------
// tb_instruction_queue_controller
// Two instances share all inputs: one with default parameters and one with a
// 4-bit bubble counter. A queue-based reference model predicts every output.
// ---------------------------------------------------------------------------
module tb_instruction_queue_controller;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clock;
    logic              reset;
    logic [3:1]        phase;
    logic [XLEN-1:0]   fetch_data;
    logic              fetch_valid;
    logic              stall;
    logic              flush;

    logic              fetch_request,  fetch_request_s;
    logic [XLEN-1:0]   cur_a, cur_s, last_a, last_s;
    logic              valid_a, valid_s;
    logic [2:0]        count_a, count_s;
    logic              empty_a, empty_s, full_a, full_s;
    logic [15:0]       bubble_a;
    logic [3:0]        bubble_s;

    instruction_queue_controller dut (
        .clock(clock), .reset(reset), .phase(phase),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .stall(stall), .flush(flush),
        .fetch_request(fetch_request),
        .current_instruction(cur_a), .last_instruction(last_a),
        .issue_valid(valid_a), .queue_count(count_a),
        .queue_empty(empty_a), .queue_full(full_a),
        .bubble_count(bubble_a)
    );

    instruction_queue_controller #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .phase(phase),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .stall(stall), .flush(flush),
        .fetch_request(fetch_request_s),
        .current_instruction(cur_s), .last_instruction(last_s),
        .issue_valid(valid_s), .queue_count(count_s),
        .queue_empty(empty_s), .queue_full(full_s),
        .bubble_count(bubble_s)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_cur, m_last;
    bit          m_valid;
    int          m_bub16, m_bub4;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur   = NOP;
        m_last  = NOP;
        m_valid = 0;
        m_bub16 = 0;
        m_bub4  = 0;
    endtask

    task automatic model_step(input logic [3:1] ph, input logic [31:0] d,
                              input logic v, input logic s, input logic f);
        if (ph == 3'b010 && v && mq.size() < DEPTH) mq.push_back(d);
        if (ph == 3'b100) begin
            if (f) begin
                mq.delete();
                m_last  = m_cur;
                m_cur   = NOP;
                m_valid = 0;
            end else if (!s) begin
                m_last = m_cur;
                if (mq.size() > 0) begin
                    m_cur   = mq.pop_front();
                    m_valid = 1;
                end else begin
                    m_cur   = NOP;
                    m_valid = 0;
                    if (m_bub16 < 65535) m_bub16++;
                    if (m_bub4 < 15) m_bub4++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("current",     cur_a,    m_cur);
        check("last",        last_a,   m_last);
        check("issue_valid", valid_a,  m_valid);
        check("count",       count_a,  mq.size());
        check("empty",       empty_a,  mq.size() == 0);
        check("full",        full_a,   mq.size() == DEPTH);
        check("bubble",      bubble_a, m_bub16);
        check("s_current",   cur_s,    m_cur);
        check("s_last",      last_s,   m_last);
        check("s_valid",     valid_s,  m_valid);
        check("s_count",     count_s,  mq.size());
        check("s_empty",     empty_s,  mq.size() == 0);
        check("s_full",      full_s,   mq.size() == DEPTH);
        check("s_bubble",    bubble_s, m_bub4);
    endtask

    // One clock: drive inputs, check the combinational request, take the
    // edge, advance the model, check registered state.
    task automatic cycle(input logic [3:1] ph, input logic [31:0] d,
                         input logic v, input logic s, input logic f);
        phase = ph; fetch_data = d; fetch_valid = v; stall = s; flush = f;
        #1;
        check("fetch_request",   fetch_request,   ph[1] && mq.size() != DEPTH);
        check("s_fetch_request", fetch_request_s, ph[1] && mq.size() != DEPTH);
        @(posedge clock);
        model_step(ph, d, v, s, f);
        #1;
        check_outputs();
    endtask

    // One full phase round: word offered at phase 2, stall/flush at phase 3.
    task automatic round(input logic [31:0] d, input logic v,
                         input logic s, input logic f);
        cycle(3'b001, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(3'b010, d,     v,    1'b0, 1'b0);
        cycle(3'b100, 32'h0, 1'b0, s,    f);
    endtask

    logic [3:1] illegal_ph [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        logic [3:1] ph;
        phase = 3'b001; fetch_data = '0; fetch_valid = 0; stall = 0; flush = 0;
        reset = 1'b0;
        model_reset();
        #12;
        check_outputs();
        @(posedge clock);
        #1 reset = 1'b1;

        // Fill with stall held, then offer a 5th word that must be dropped.
        round(32'h0010_0093, 1, 1, 0);
        round(32'h0020_0113, 1, 1, 0);
        round(32'h0030_0193, 1, 1, 0);
        round(32'h0040_0213, 1, 1, 0);
        check("fill_full", full_a, 1'b1);
        round(32'hDEAD_BEEF, 1, 1, 0);
        check("fill_count", count_a, 3'd4);

        // Drain in order, then one underflow bubble.
        for (int i = 0; i < 5; i++) round(32'h0, 0, 0, 0);
        check("drain_bubble", bubble_a, 16'd1);

        // Flush with three words queued and stall also high.
        for (int i = 0; i < 3; i++) round(32'h0050_0293 + 32'(i), 1, 1, 0);
        round(32'h0, 0, 1, 1);
        check("flush_count", count_a, 3'd0);
        round(32'h0060_0313, 1, 0, 0);
        check("post_flush_issue", cur_a, 32'h0060_0313);

        // Wrap-around with mixed stalls to vary occupancy.
        for (int i = 0; i < 10; i++) round(32'h1000_0000 + 32'(i), 1, (i % 3) == 0, 0);

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) round(32'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++) round(32'h0, 0, 0, 0);
        check("sat_final", bubble_s, 4'd15);

        // Reset asserted mid phase 2 takes effect without an edge.
        round(32'h0070_0393, 1, 1, 0);
        phase = 3'b010; fetch_data = 32'h0080_0413; fetch_valid = 1; stall = 0; flush = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clock);
        #1 reset = 1'b1;
        cycle(3'b001, 32'h0, 0, 0, 0);
        check("reset_fetch_req", fetch_request, 1'b1);
        cycle(3'b010, 32'h0, 0, 0, 0);
        cycle(3'b100, 32'h0, 0, 0, 0);

        // Randomised phase traffic, including illegal phase vectors and
        // stall/flush/valid asserted outside their phases.
        ph = 3'b001;
        for (int i = 0; i < 600; i++) begin
            logic [3:1] use_ph;
            if ($urandom_range(0, 15) == 0) begin
                use_ph = illegal_ph[$urandom_range(0, 4)];
            end else begin
                use_ph = ph;
                ph     = {ph[2:1], ph[3]};
            end
            cycle(use_ph, $urandom(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
